// File: rtl/div_feed_if.sv
// Request, divider-side and result bundle for div_feed.
// The slave modport is the div_feed view; master is the requester/divider/consumer view.
interface div_feed_if #(
  parameter int unsigned DIVIDEND_WIDTH = 21,
  parameter int unsigned DIVISOR_WIDTH  = 12,
  parameter int unsigned OUTPUT_WIDTH   = 22,
  parameter int unsigned TAG_WIDTH      = 4
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] in_dividend;
  logic [DIVISOR_WIDTH-1:0]  in_divisor;
  logic [TAG_WIDTH-1:0]      in_tag;

  logic [DIVIDEND_WIDTH-1:0] div_dividend;
  logic [DIVISOR_WIDTH-1:0]  div_divisor;
  logic                      div_pull;
  logic                      div_push;
  logic [OUTPUT_WIDTH-1:0]   div_quotient;

  logic                      out_valid;
  logic                      out_ready;
  logic [OUTPUT_WIDTH-1:0]   out_quotient;
  logic [TAG_WIDTH-1:0]      out_tag;

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_tag,
    input  div_pull, div_push, div_quotient, out_ready,
    output in_ready, div_dividend, div_divisor,
    output out_valid, out_quotient, out_tag
  );

  modport master (
    output in_valid, in_dividend, in_divisor, in_tag,
    output div_pull, div_push, div_quotient, out_ready,
    input  in_ready, div_dividend, div_divisor,
    input  out_valid, out_quotient, out_tag
  );
endinterface

// File: rtl/div_feed.sv
// Feeds operands to a fixed-latency strobed divider, tracks tags through a
// push-advanced slot pipe and buffers results in a credit-protected FIFO.
module div_feed #(
  parameter int unsigned DIVIDEND_WIDTH = 21,
  parameter int unsigned DIVISOR_WIDTH  = 12,
  parameter int unsigned OUTPUT_WIDTH   = 22,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned DIV_LATENCY    = 8,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  div_feed_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned INF_W = $clog2(DIV_LATENCY + 2);

  logic [DIVIDEND_WIDTH-1:0] div_dividend_q, div_dividend_d;
  logic [DIVISOR_WIDTH-1:0]  div_divisor_q, div_divisor_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [TAG_WIDTH-1:0]      pend_tag_q, pend_tag_d;
  logic [DIV_LATENCY-1:0]    slot_valid_q, slot_valid_d;
  logic [TAG_WIDTH-1:0]      slot_tag_q [DIV_LATENCY];
  logic [TAG_WIDTH-1:0]      slot_tag_d [DIV_LATENCY];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          fifo_count_q, fifo_count_d;
  logic                      live_q, live_d;
  logic [OUTPUT_WIDTH-1:0]   fifo_quot_q [FIFO_DEPTH];
  logic [OUTPUT_WIDTH-1:0]   fifo_quot_d [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]      fifo_tag_q [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]      fifo_tag_d [FIFO_DEPTH];

  logic [INF_W-1:0] inflight_c;
  logic             credit_ok_c, in_ready_c, launch_c, fifo_wr_c, fifo_rd_c;

  // Credits count every result that may still land in the FIFO, so a write can never overflow.
  always_comb begin
    inflight_c = INF_W'(pend_valid_q);
    for (int i = 0; i < int'(DIV_LATENCY); i++) begin
      inflight_c = inflight_c + INF_W'(slot_valid_q[i]);
    end
    credit_ok_c = (SUM_W'(fifo_count_q) + SUM_W'(inflight_c)) < SUM_W'(FIFO_DEPTH);
    in_ready_c  = bus.div_pull && credit_ok_c && live_q;
    launch_c    = bus.in_valid && in_ready_c;
    fifo_wr_c   = bus.div_push && slot_valid_q[DIV_LATENCY-1];
    fifo_rd_c   = (fifo_count_q != '0) && bus.out_ready;
  end

  always_comb begin
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    pend_valid_d   = pend_valid_q;
    pend_tag_d     = pend_tag_q;
    slot_valid_d   = slot_valid_q;
    slot_tag_d     = slot_tag_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_count_d   = fifo_count_q;
    fifo_quot_d    = fifo_quot_q;
    fifo_tag_d     = fifo_tag_q;
    live_d         = 1'b1;

    // Push consumes the old pending slot before a same-cycle pull refills it.
    if (bus.div_push) begin
      slot_valid_d[0] = pend_valid_q;
      slot_tag_d[0]   = pend_tag_q;
      for (int i = 1; i < int'(DIV_LATENCY); i++) begin
        slot_valid_d[i] = slot_valid_q[i-1];
        slot_tag_d[i]   = slot_tag_q[i-1];
      end
      pend_valid_d = 1'b0;
    end

    if (bus.div_pull) begin
      pend_valid_d = launch_c;
      pend_tag_d   = launch_c ? bus.in_tag : '0;
      if (launch_c) begin
        div_dividend_d = bus.in_dividend;
        div_divisor_d  = bus.in_divisor;
      end
    end

    if (fifo_wr_c) begin
      fifo_quot_d[wr_ptr_q] = bus.div_quotient;
      fifo_tag_d[wr_ptr_q]  = slot_tag_q[DIV_LATENCY-1];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_rd_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_wr_c, fifo_rd_c})
      2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      pend_valid_q   <= 1'b0;
      pend_tag_q     <= '0;
      slot_valid_q   <= '0;
      slot_tag_q     <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
      live_q         <= 1'b0;
    end else begin
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
      pend_valid_q   <= pend_valid_d;
      pend_tag_q     <= pend_tag_d;
      slot_valid_q   <= slot_valid_d;
      slot_tag_q     <= slot_tag_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_count_q   <= fifo_count_d;
      live_q         <= live_d;
    end
  end

  // Storage only; validity is governed by the reset pointers and count.
  always_ff @(posedge clk) begin
    fifo_quot_q <= fifo_quot_d;
    fifo_tag_q  <= fifo_tag_d;
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;
  assign bus.out_valid    = (fifo_count_q != '0);
  assign bus.out_quotient = fifo_quot_q[rd_ptr_q];
  assign bus.out_tag      = fifo_tag_q[rd_ptr_q];
endmodule

// File: doc/div_feed.md
DIV_FEED -- requirements
Module: div_feed

Interface
REQ-001 SHALL have parameter DIVIDEND_WIDTH, default 21, operand dividend width.
REQ-002 SHALL have parameter DIVISOR_WIDTH, default 12, operand divisor width.
REQ-003 SHALL have parameter OUTPUT_WIDTH, default 22, divider quotient width.
REQ-004 SHALL have parameter TAG_WIDTH, default 4, width of the caller tag carried alongside each operation.
REQ-005 SHALL have parameter DIV_LATENCY, default 8, number of div_push strobes from operand launch to the matching quotient.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, result FIFO depth; power of two and at least DIV_LATENCY+1.
REQ-007 SHALL use one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-008 SHALL have these request ports: in_valid  in  1  request valid; in_ready  out  1  request accepted this cycle; in_dividend  in  DIVIDEND_WIDTH  signed dividend; in_divisor  in  DIVISOR_WIDTH  signed divisor; in_tag  in  TAG_WIDTH  caller tag.
REQ-009 SHALL have these divider-side ports: div_dividend  out  DIVIDEND_WIDTH  registered operand to divider; div_divisor  out  DIVISOR_WIDTH  registered operand to divider; div_pull  in  1  divider operand strobe; div_push  in  1  divider result strobe; div_quotient  in  OUTPUT_WIDTH  divider result.
REQ-010 SHALL have these result ports: out_valid  out  1  FIFO non-empty; out_ready  in  1  consumer pop; out_quotient  out  OUTPUT_WIDTH  head quotient; out_tag  out  TAG_WIDTH  head tag.

Function
REQ-011 SHALL derive credit_ok from registered state at the start of the cycle: credit_ok = (fifo_count + in-flight valid slots) < FIFO_DEPTH.
REQ-012 SHALL drive in_ready = div_pull && credit_ok, combinationally.
REQ-013 SHALL launch an operation when in_valid && in_ready: operands load into div_dividend/div_divisor on that clock edge; the pending slot becomes {valid=1, in_tag}.
REQ-014 SHALL handle a div_pull cycle with no launch by holding div_dividend/div_divisor unchanged and setting the pending slot to {valid=0} (bubble).
REQ-015 SHALL keep div_dividend/div_divisor stable between consecutive div_pull strobes.
REQ-016 SHALL keep a DIV_LATENCY-entry slot shift register {valid, tag} that advances only on div_push; the head is loaded from the pending slot and the pending slot then clears.
REQ-017 SHALL resolve div_pull and div_push in the same cycle as: the shift register takes the old pending slot, and the pending slot takes the new launch or bubble.
REQ-018 SHALL, on div_push with a valid tail entry, write {div_quotient, tail tag} into the FIFO; a tail bubble writes nothing.
REQ-019 SHALL keep the FIFO in order: out_valid = (fifo_count != 0); out_quotient/out_tag show the head entry; pop on out_valid && out_ready.
REQ-020 SHALL leave fifo_count unchanged on a simultaneous FIFO write and pop; a pop with fifo_count=0 is ignored.
REQ-021 SHALL guarantee by REQ-011 that a FIFO write never occurs when full; overflow is unreachable.
REQ-022 SHALL pass tags through unmodified and never reorder results.

Reset
REQ-023 SHALL, while rst_n=0, clear the FIFO pointers and count, all slot valids, the pending slot, div_dividend and div_divisor to 0; out_valid=0, in_ready=0.
REQ-024 SHALL discard in-flight operations on reset mid-operation with no later output; the system resets the divider in the same interval.

Verification (bench divider model: period 4, pull and push both every 4th cycle, latency 8 pushes)
REQ-025 SHALL verify reset: rst_n=0 with random inputs -> out_valid=0, in_ready=0, div_dividend=0, div_divisor=0.
REQ-026 SHALL verify a single operation: dividend=100, divisor=4, tag=3 -> accepted at first pull; div_dividend=100, div_divisor=4 next cycle; out_valid with quotient=25<<6 and tag=3 after the 8th following push.
REQ-027 SHALL verify streaming: 20 requests with tags 0..15,0..3 and out_ready=1 -> one acceptance per 4 cycles, all 20 results in order with tags intact.
REQ-028 SHALL verify backpressure: out_ready=0 with continuous requests -> exactly 16 accepted, then in_ready=0 indefinitely; out_ready=1 drains 16 in order and acceptance resumes with no loss.
REQ-029 SHALL verify bubbles: in_valid=0 at alternate pulls -> no FIFO write on matching pushes; fifo_count matches accepted count.
REQ-030 SHALL verify mid-flight reset: 3 operations in flight, then rst_n low for 2 cycles -> out_valid stays 0 until new requests complete.
